// File: rtl/pg_ctrl.sv
// pg_ctrl: power-gating sequencer for the core's gated domain.
// Orders clock-gate, isolation, domain reset and power-switch controls on
// power-down and wake-up. The power-switch acknowledge closes the loop, and
// an edge timeout forces progress if the acknowledge never arrives.
module pg_ctrl #(
  parameter int unsigned STEP_CYC = 4,   // edges held in each timed step, 1..255
  parameter int unsigned ACK_TO   = 255  // edges to wait for pwr_ack, 1..255
) (
  input  logic cpu_clk,
  input  logic cpu_rstn,
  input  logic pg_req,
  input  logic pg_wake,
  input  logic pwr_ack,
  output logic pwr_sw_en,
  output logic pg_clk_en,
  output logic pg_iso_en,
  output logic pg_resetn,
  output logic pg_off,
  output logic pg_busy,
  output logic pg_err
);

  typedef enum logic [3:0] {
    S_ON,
    S_CLK_OFF,
    S_ISO_ON,
    S_RST_ON,
    S_PWR_OFF,
    S_OFF,
    S_PWR_ON,
    S_CLK_ON,
    S_RST_REL,
    S_ISO_OFF
  } state_e;

  // The counter advances on the edge that samples this value, so a step
  // state is held exactly STEP_CYC edges and an ack wait times out on the
  // ACK_TO-th edge spent waiting.
  localparam logic [7:0] STEP_LAST = 8'(STEP_CYC - 1);
  localparam logic [7:0] ACK_LAST  = 8'(ACK_TO - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req_q;
  logic       wake_pend_q, wake_pend_d;
  logic       err_q, err_set;
  logic       pwr_sw_en_q, pg_clk_en_q, pg_iso_en_q, pg_resetn_q;
  logic       pg_off_q, pg_busy_q;

  logic start;
  logic step_done;
  logic ack_expired;
  logic state_change;

  // Control vector {pwr_sw_en, pg_clk_en, pg_iso_en, pg_resetn} per state.
  function automatic logic [3:0] ctrl_vec(input state_e s);
    logic [3:0] v;
    case (s)
      S_ON:      v = 4'b1101;
      S_CLK_OFF: v = 4'b1001;
      S_ISO_ON:  v = 4'b1011;
      S_RST_ON:  v = 4'b1010;
      S_PWR_OFF: v = 4'b0010;
      S_OFF:     v = 4'b0010;
      S_PWR_ON:  v = 4'b1010;
      S_CLK_ON:  v = 4'b1110;
      S_RST_REL: v = 4'b1111;
      S_ISO_OFF: v = 4'b1101;
      default:   v = 4'b1101;
    endcase
    return v;
  endfunction

  assign start       = pg_req & ~req_q;
  assign step_done   = (cnt_q == STEP_LAST);
  assign ack_expired = (cnt_q == ACK_LAST);

  // Next-state selection, timeout error detection and counter/pending updates.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    err_set     = 1'b0;
    cnt_d       = 8'd0;
    wake_pend_d = wake_pend_q;

    case (state_q)
      S_ON:      if (start)     state_d = S_CLK_OFF;
      S_CLK_OFF: if (step_done) state_d = S_ISO_ON;
      S_ISO_ON:  if (step_done) state_d = S_RST_ON;
      S_RST_ON:  if (step_done) state_d = S_PWR_OFF;
      S_PWR_OFF: begin
        if (!pwr_ack) begin
          state_d = S_OFF;
        end else if (ack_expired) begin
          state_d = S_OFF;
          err_set = 1'b1;
        end
      end
      S_OFF:     if (pg_wake || wake_pend_q) state_d = S_PWR_ON;
      S_PWR_ON: begin
        if (pwr_ack) begin
          state_d = S_CLK_ON;
        end else if (ack_expired) begin
          state_d = S_CLK_ON;
          err_set = 1'b1;
        end
      end
      S_CLK_ON:  if (step_done) state_d = S_RST_REL;
      S_RST_REL: if (step_done) state_d = S_ISO_OFF;
      S_ISO_OFF: if (step_done) state_d = S_ON;
      default:   state_d = S_ON;
    endcase

    state_change = (state_d != state_q);

    // One counter serves both the step timing and the ack timeout: the two
    // uses never overlap in the same state. It only runs in sequence states.
    if (!state_change && state_q != S_ON && state_q != S_OFF) begin
      cnt_d = cnt_q + 8'd1;
    end

    // A wake seen outside ON is remembered until the domain starts powering up.
    if (state_change && state_d == S_PWR_ON) begin
      wake_pend_d = 1'b0;
    end else if (pg_wake && state_q != S_ON) begin
      wake_pend_d = 1'b1;
    end
  end

  // State, counters and registered outputs; outputs follow the state being entered.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q     <= S_ON;
      cnt_q       <= 8'd0;
      req_q       <= 1'b0;
      wake_pend_q <= 1'b0;
      err_q       <= 1'b0;
      pwr_sw_en_q <= 1'b1;
      pg_clk_en_q <= 1'b1;
      pg_iso_en_q <= 1'b0;
      pg_resetn_q <= 1'b1;
      pg_off_q    <= 1'b0;
      pg_busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= pg_req;
      wake_pend_q <= wake_pend_d;
      err_q       <= err_q | err_set;
      {pwr_sw_en_q, pg_clk_en_q, pg_iso_en_q, pg_resetn_q} <= ctrl_vec(state_d);
      pg_off_q    <= (state_d == S_OFF);
      pg_busy_q   <= (state_d != S_ON) && (state_d != S_OFF);
    end
  end

  assign pwr_sw_en = pwr_sw_en_q;
  assign pg_clk_en = pg_clk_en_q;
  assign pg_iso_en = pg_iso_en_q;
  assign pg_resetn = pg_resetn_q;
  assign pg_off    = pg_off_q;
  assign pg_busy   = pg_busy_q;
  assign pg_err    = err_q;

endmodule
